// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 scan-code constants, parser state encoding and key event type.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE    = 8'hE1;
    localparam logic [7:0] BAT          = 8'hAA;
    localparam logic [7:0] ACK          = 8'hFA;
    localparam logic [7:0] ECHO         = 8'hEE;
    localparam logic [7:0] RESEND       = 8'hFE;
    localparam logic [7:0] ERR0         = 8'h00;
    localparam logic [7:0] ERR1         = 8'hFF;
    localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
    localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_PAUSE
    } parser_state_t;

    typedef struct packed {
        logic       make;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of key events; push into a full FIFO is dropped unless a pop
// frees a slot in the same cycle. Pop on empty is ignored.
module ps2_event_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  key_event_t push_dat,
    input  logic       pop,
    output key_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    key_event_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Decodes PS/2 scan bytes (E0/F0/E1 prefixes) into make/break events, tracks held
// keys to filter typematic repeats, and queues events behind a valid/ready FIFO.
module ps2_key_event_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int MAX_HELD      = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic                            code_ready,
    input  logic [7:0]                      code_in,
    output logic                            code_read,
    output logic                            ev_valid,
    input  logic                            ev_ready,
    output logic                            ev_make,
    output logic                            ev_ext,
    output logic [7:0]                      ev_code,
    output logic [$clog2(MAX_HELD+1)-1:0]   held_count,
    output logic                            table_full,
    output logic                            fifo_ovf,
    input  logic                            clear_held
);

    localparam int CW = $clog2(MAX_HELD+1);

    parser_state_t state;
    logic [2:0]    skip_cnt;
    logic [1:0]    guard_cnt;
    logic          accept;
    key_event_t    pend;
    logic          pend_vld;
    logic          pend_store;

    logic [MAX_HELD-1:0] tbl_vld;
    logic [8:0]          tbl_key [MAX_HELD];
    logic [MAX_HELD-1:0] hit_oh;
    logic [MAX_HELD-1:0] free_oh;
    logic                hit;
    logic                free_any;
    logic                is_make;
    logic                drop;
    logic                push;
    logic                pop;
    logic                do_insert;
    logic                do_remove;
    logic                full_set;
    logic                fifo_full;
    logic                fifo_empty;
    key_event_t          head;

    // Guard spans the code_read cycle plus one, so a held code_ready is taken once.
    assign accept = code_ready && (guard_cnt == 2'd0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= ST_IDLE;
            skip_cnt   <= '0;
            guard_cnt  <= '0;
            code_read  <= 1'b0;
            pend_vld   <= 1'b0;
            pend_store <= 1'b0;
            pend       <= '0;
        end else begin
            code_read <= accept;
            pend_vld  <= 1'b0;
            if (guard_cnt != 2'd0) guard_cnt <= guard_cnt - 2'd1;
            if (accept) begin
                guard_cnt  <= 2'd2;
                pend_store <= 1'b1;
                case (state)
                    ST_IDLE: begin
                        case (code_in)
                            PS2_EXT:   state <= ST_E0;
                            PS2_BRK:   state <= ST_F0;
                            PS2_PAUSE: begin
                                state    <= ST_PAUSE;
                                skip_cnt <= 3'd7;
                            end
                            BAT, ACK, ECHO, RESEND, ERR0, ERR1: begin
                            end
                            default: begin
                                pend_vld <= 1'b1;
                                pend     <= '{1'b1, 1'b0, code_in};
                            end
                        endcase
                    end
                    ST_E0: begin
                        if (code_in == PS2_BRK) begin
                            state <= ST_E0F0;
                        end else begin
                            state <= ST_IDLE;
                            if (code_in != FAKE_SHIFT_L && code_in != FAKE_SHIFT_R) begin
                                pend_vld <= 1'b1;
                                pend     <= '{1'b1, 1'b1, code_in};
                            end
                        end
                    end
                    ST_F0: begin
                        state    <= ST_IDLE;
                        pend_vld <= 1'b1;
                        pend     <= '{1'b0, 1'b0, code_in};
                    end
                    ST_E0F0: begin
                        state    <= ST_IDLE;
                        pend_vld <= 1'b1;
                        pend     <= '{1'b0, 1'b1, code_in};
                    end
                    ST_PAUSE: begin
                        skip_cnt <= skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) begin
                            state      <= ST_IDLE;
                            pend_vld   <= 1'b1;
                            pend_store <= 1'b0;
                            pend       <= '{1'b1, 1'b1, PS2_PAUSE};
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        hit_oh = '0;
        for (int i = 0; i < MAX_HELD; i++) begin
            hit_oh[i] = tbl_vld[i] && (tbl_key[i] == {pend.ext, pend.code});
        end
    end

    // Lowest clear bit of the valid vector picks the insertion slot.
    assign free_oh   = ~tbl_vld & (tbl_vld + MAX_HELD'(1));
    assign hit       = |hit_oh;
    assign free_any  = |free_oh;
    assign is_make   = pend_vld && pend.make;
    assign drop      = is_make && hit && (FILTER_REPEAT != 0);
    assign push      = pend_vld && !drop;
    assign do_insert = is_make && pend_store && !hit && free_any;
    assign full_set  = is_make && pend_store && !hit && !free_any;
    assign do_remove = pend_vld && !pend.make && hit;
    assign pop       = ev_valid && ev_ready;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tbl_vld    <= '0;
            table_full <= 1'b0;
            fifo_ovf   <= 1'b0;
        end else begin
            if (clear_held)     tbl_vld <= '0;
            else if (do_insert) tbl_vld <= tbl_vld | free_oh;
            else if (do_remove) tbl_vld <= tbl_vld & ~hit_oh;
            if (full_set) table_full <= 1'b1;
            if (push && fifo_full && !pop) fifo_ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < MAX_HELD; i++) begin
            if (do_insert && free_oh[i]) tbl_key[i] <= {pend.ext, pend.code};
        end
    end

    always_comb begin
        held_count = '0;
        for (int i = 0; i < MAX_HELD; i++) begin
            held_count = held_count + CW'(tbl_vld[i]);
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .reset    (reset),
        .push     (push),
        .push_dat (pend),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_make  = head.make;
    assign ev_ext   = head.ext;
    assign ev_code  = head.code;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder: default instance plus a FILTER_REPEAT=0 twin.
module tb_ps2_key_event_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       code_ready = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       ev_ready = 1'b0;
    logic       clear_held = 1'b0;

    logic       code_read, ev_valid, ev_make, ev_ext, table_full, fifo_ovf;
    logic [7:0] ev_code;
    logic [2:0] held_count;

    logic       nf_code_read, nf_ev_valid, nf_ev_make, nf_ev_ext, nf_table_full, nf_fifo_ovf;
    logic [7:0] nf_ev_code;
    logic [2:0] nf_held_count;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] q [$];
    logic [9:0] qn [$];
    int         cr_cnt = 0;
    logic       cr_wide = 1'b0;
    logic       prev_cr = 1'b0;

    always #5 clk = ~clk;

    ps2_key_event_decoder #(.MAX_HELD(4), .FIFO_DEPTH(4), .FILTER_REPEAT(1)) dut (
        .CLOCK_50(clk), .reset(reset), .code_ready(code_ready), .code_in(code_in),
        .code_read(code_read), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_make(ev_make), .ev_ext(ev_ext), .ev_code(ev_code),
        .held_count(held_count), .table_full(table_full), .fifo_ovf(fifo_ovf),
        .clear_held(clear_held)
    );

    ps2_key_event_decoder #(.MAX_HELD(4), .FIFO_DEPTH(4), .FILTER_REPEAT(0)) dut_nf (
        .CLOCK_50(clk), .reset(reset), .code_ready(code_ready), .code_in(code_in),
        .code_read(nf_code_read), .ev_valid(nf_ev_valid), .ev_ready(ev_ready),
        .ev_make(nf_ev_make), .ev_ext(nf_ev_ext), .ev_code(nf_ev_code),
        .held_count(nf_held_count), .table_full(nf_table_full), .fifo_ovf(nf_fifo_ovf),
        .clear_held(clear_held)
    );

    // Handshakes seen at the negedge commit on the following posedge.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            qn.delete();
            cr_cnt  = 0;
            cr_wide = 1'b0;
            prev_cr = 1'b0;
        end else begin
            if (ev_valid && ev_ready) q.push_back({ev_make, ev_ext, ev_code});
            if (nf_ev_valid && ev_ready) qn.push_back({nf_ev_make, nf_ev_ext, nf_ev_code});
            if (code_read) cr_cnt++;
            if (code_read && prev_cr) cr_wide = 1'b1;
            prev_cr = code_read;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        code_ready = 1'b0;
        clear_held = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    // code_ready is held through the guard window to show a byte is taken once.
    task automatic send_byte(input logic [7:0] b);
        code_ready = 1'b1;
        code_in    = b;
        tick;
        tick;
        tick;
        code_ready = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        ev_ready = 1'b1;
        do_reset;
        sample;
        n_vec++; if (code_read !== 1'b0) begin n_err++; $display("FAIL reset_code_read got=%b exp=0", code_read); end
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_ev_valid got=%b exp=0", ev_valid); end
        n_vec++; if (held_count !== 3'd0) begin n_err++; $display("FAIL reset_held_count got=%0d exp=0", held_count); end
        n_vec++; if (table_full !== 1'b0) begin n_err++; $display("FAIL reset_table_full got=%b exp=0", table_full); end
        n_vec++; if (fifo_ovf !== 1'b0) begin n_err++; $display("FAIL reset_fifo_ovf got=%b exp=0", fifo_ovf); end
    endtask

    task automatic test_latency;
        ev_ready = 1'b0;
        do_reset;
        code_ready = 1'b1;
        code_in    = 8'h1C;
        tick;
        code_ready = 1'b0;
        sample;
        n_vec++; if (code_read !== 1'b1) begin n_err++; $display("FAIL lat_code_read_1 got=%b exp=1", code_read); end
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL lat_ev_valid_1 got=%b exp=0", ev_valid); end
        tick;
        sample;
        n_vec++; if (code_read !== 1'b0) begin n_err++; $display("FAIL lat_code_read_2 got=%b exp=0", code_read); end
        n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL lat_ev_valid_2 got=%b exp=1", ev_valid); end
        n_vec++; if ({ev_make, ev_ext, ev_code} !== {1'b1, 1'b0, 8'h1C}) begin n_err++; $display("FAIL lat_head got=%h exp=%h", {ev_make, ev_ext, ev_code}, {1'b1, 1'b0, 8'h1C}); end
        n_vec++; if (held_count !== 3'd1) begin n_err++; $display("FAIL lat_held got=%0d exp=1", held_count); end
    endtask

    task automatic test_make_break;
        ev_ready = 1'b1;
        do_reset;
        send_byte(8'h1C);
        sample;
        n_vec++; if (held_count !== 3'd1) begin n_err++; $display("FAIL mb_held_after_make got=%0d exp=1", held_count); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        tick; tick;
        sample;
        n_vec++; if (q.size() !== 2) begin n_err++; $display("FAIL mb_count got=%0d exp=2", q.size()); end
        n_vec++; if (q[0] !== {1'b1, 1'b0, 8'h1C}) begin n_err++; $display("FAIL mb_ev0 got=%h exp=%h", q[0], {1'b1, 1'b0, 8'h1C}); end
        n_vec++; if (q[1] !== {1'b0, 1'b0, 8'h1C}) begin n_err++; $display("FAIL mb_ev1 got=%h exp=%h", q[1], {1'b0, 1'b0, 8'h1C}); end
        n_vec++; if (held_count !== 3'd0) begin n_err++; $display("FAIL mb_held_after_break got=%0d exp=0", held_count); end
        n_vec++; if (cr_cnt !== 3) begin n_err++; $display("FAIL mb_code_read_pulses got=%0d exp=3", cr_cnt); end
        n_vec++; if (cr_wide !== 1'b0) begin n_err++; $display("FAIL mb_code_read_width got=%b exp=0", cr_wide); end
    endtask

    task automatic test_repeat;
        ev_ready = 1'b1;
        do_reset;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        tick; tick;
        sample;
        n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL rep_filtered_count got=%0d exp=1", q.size()); end
        n_vec++; if (q[0] !== {1'b1, 1'b0, 8'h1C}) begin n_err++; $display("FAIL rep_filtered_ev got=%h exp=%h", q[0], {1'b1, 1'b0, 8'h1C}); end
        n_vec++; if (qn.size() !== 3) begin n_err++; $display("FAIL rep_unfiltered_count got=%0d exp=3", qn.size()); end
        n_vec++; if (qn[2] !== {1'b1, 1'b0, 8'h1C}) begin n_err++; $display("FAIL rep_unfiltered_ev got=%h exp=%h", qn[2], {1'b1, 1'b0, 8'h1C}); end
        n_vec++; if (nf_held_count !== 3'd1) begin n_err++; $display("FAIL rep_unfiltered_held got=%0d exp=1", nf_held_count); end
    endtask

    task automatic test_extended;
        ev_ready = 1'b1;
        do_reset;
        send_byte(8'hE0);
        send_byte(8'h75);
        tick;
        sample;
        n_vec++; if (held_count !== 3'd1) begin n_err++; $display("FAIL ext_held got=%0d exp=1", held_count); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'hAA);
        send_byte(8'hE0);
        send_byte(8'h12);
        tick; tick;
        sample;
        n_vec++; if (q.size() !== 2) begin n_err++; $display("FAIL ext_count got=%0d exp=2", q.size()); end
        n_vec++; if (q[0] !== {1'b1, 1'b1, 8'h75}) begin n_err++; $display("FAIL ext_make got=%h exp=%h", q[0], {1'b1, 1'b1, 8'h75}); end
        n_vec++; if (q[1] !== {1'b0, 1'b1, 8'h75}) begin n_err++; $display("FAIL ext_break got=%h exp=%h", q[1], {1'b0, 1'b1, 8'h75}); end
        n_vec++; if (held_count !== 3'd0) begin n_err++; $display("FAIL ext_held_end got=%0d exp=0", held_count); end
        n_vec++; if (cr_cnt !== 8) begin n_err++; $display("FAIL ext_code_read_pulses got=%0d exp=8", cr_cnt); end
    endtask

    task automatic test_table_full;
        ev_ready = 1'b1;
        do_reset;
        send_byte(8'h15);
        send_byte(8'h1D);
        send_byte(8'h24);
        send_byte(8'h2D);
        send_byte(8'h2C);
        tick; tick;
        sample;
        n_vec++; if (q.size() !== 5) begin n_err++; $display("FAIL full_count got=%0d exp=5", q.size()); end
        n_vec++; if (q[4] !== {1'b1, 1'b0, 8'h2C}) begin n_err++; $display("FAIL full_fifth got=%h exp=%h", q[4], {1'b1, 1'b0, 8'h2C}); end
        n_vec++; if (held_count !== 3'd4) begin n_err++; $display("FAIL full_held got=%0d exp=4", held_count); end
        n_vec++; if (table_full !== 1'b1) begin n_err++; $display("FAIL full_flag got=%b exp=1", table_full); end
        send_byte(8'hF0);
        send_byte(8'h2C);
        tick; tick;
        sample;
        n_vec++; if (q.size() !== 6) begin n_err++; $display("FAIL full_brk_count got=%0d exp=6", q.size()); end
        n_vec++; if (q[5] !== {1'b0, 1'b0, 8'h2C}) begin n_err++; $display("FAIL full_brk_ev got=%h exp=%h", q[5], {1'b0, 1'b0, 8'h2C}); end
        n_vec++; if (held_count !== 3'd4) begin n_err++; $display("FAIL full_brk_held got=%0d exp=4", held_count); end
        tick;
        clear_held = 1'b1;
        tick;
        clear_held = 1'b0;
        sample;
        n_vec++; if (held_count !== 3'd0) begin n_err++; $display("FAIL clear_held got=%0d exp=0", held_count); end
        n_vec++; if (table_full !== 1'b1) begin n_err++; $display("FAIL clear_sticky got=%b exp=1", table_full); end
        n_vec++; if (q.size() !== 6) begin n_err++; $display("FAIL clear_no_event got=%0d exp=6", q.size()); end
    endtask

    task automatic test_overflow;
        ev_ready = 1'b0;
        do_reset;
        send_byte(8'h15);
        send_byte(8'h1D);
        send_byte(8'h24);
        send_byte(8'h2D);
        send_byte(8'h2C);
        send_byte(8'h1C);
        sample;
        n_vec++; if (fifo_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", fifo_ovf); end
        n_vec++; if (held_count !== 3'd4) begin n_err++; $display("FAIL ovf_held got=%0d exp=4", held_count); end
        n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid got=%b exp=1", ev_valid); end
        tick;
        ev_ready = 1'b1;
        repeat (8) tick;
        sample;
        n_vec++; if (q.size() !== 4) begin n_err++; $display("FAIL ovf_drain_count got=%0d exp=4", q.size()); end
        n_vec++; if (q[0] !== {1'b1, 1'b0, 8'h15}) begin n_err++; $display("FAIL ovf_ev0 got=%h exp=%h", q[0], {1'b1, 1'b0, 8'h15}); end
        n_vec++; if (q[1] !== {1'b1, 1'b0, 8'h1D}) begin n_err++; $display("FAIL ovf_ev1 got=%h exp=%h", q[1], {1'b1, 1'b0, 8'h1D}); end
        n_vec++; if (q[2] !== {1'b1, 1'b0, 8'h24}) begin n_err++; $display("FAIL ovf_ev2 got=%h exp=%h", q[2], {1'b1, 1'b0, 8'h24}); end
        n_vec++; if (q[3] !== {1'b1, 1'b0, 8'h2D}) begin n_err++; $display("FAIL ovf_ev3 got=%h exp=%h", q[3], {1'b1, 1'b0, 8'h2D}); end
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained_valid got=%b exp=0", ev_valid); end
        n_vec++; if (fifo_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", fifo_ovf); end
    endtask

    task automatic test_pause;
        ev_ready = 1'b1;
        do_reset;
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        tick; tick;
        sample;
        n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL pause_count got=%0d exp=1", q.size()); end
        n_vec++; if (q[0] !== {1'b1, 1'b1, 8'hE1}) begin n_err++; $display("FAIL pause_ev got=%h exp=%h", q[0], {1'b1, 1'b1, 8'hE1}); end
        n_vec++; if (held_count !== 3'd0) begin n_err++; $display("FAIL pause_held got=%0d exp=0", held_count); end
    endtask

    task automatic test_reset_mid;
        ev_ready = 1'b1;
        do_reset;
        send_byte(8'hE0);
        do_reset;
        send_byte(8'h75);
        tick; tick;
        sample;
        n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL rmid_count got=%0d exp=1", q.size()); end
        n_vec++; if (q[0] !== {1'b1, 1'b0, 8'h75}) begin n_err++; $display("FAIL rmid_ev got=%h exp=%h", q[0], {1'b1, 1'b0, 8'h75}); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_make_break;
        test_repeat;
        test_extended;
        test_table_full;
        test_overflow;
        test_pause;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
